trigger_capture: RTL and testbench
==================================

Name: trigger_capture

Overview:
Acquisition stage directly upstream of the trigger ROM/frame-buffer copy stage. Watches the ADC sample stream for a level crossing of the selected slope, or forces a trigger after a timeout in auto mode. Then records the next 256 decimated samples into a parallel output array and hands them off with a read/ready handshake. Holds the array stable until the downstream copy has finished.

Parameters:
DEPTH, 256, samples per capture; fixed array size for data_out.
AUTO_TIMEOUT, 4096, decimated samples searched before auto mode forces a trigger.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  asynchronous, active-low reset.
sample_in  input  12  ADC sample, unsigned.
sample_valid  input  1  one-cycle strobe; sample_in is valid this cycle.
trig_level  input  12  trigger threshold, unsigned; sampled continuously.
trig_slope  input  1  0 = rising-edge trigger, 1 = falling-edge trigger.
auto_mode  input  1  1 = enable forced trigger after AUTO_TIMEOUT.
decim  input  4  keep one of every decim+1 valid samples; 0 = keep every sample.
ready  input  1  downstream idle/accepting; low while copying.
read  output  1  capture complete; request downstream copy.
data_out  output  12 x [0:DEPTH-1]  captured samples; index 0 is the trigger sample.
triggered  output  1  high from the trigger event until return to ARM; status/LED.
busy  output  1  high in every state except ARM.

Behaviour:
- Reset (rst low, asynchronous): state = ARM; read = 0; triggered = 0; busy = 0; all data_out = 0; counters = 0; prev_valid = 0.
- Decimator: 4-bit counter advances on sample_valid. A kept sample ("tick") occurs when the counter equals decim; the counter then resets to 0. The counter is cleared on entry to SEARCH. If decim changes mid-run, the new value applies from the next comparison.
- All states below act only on ticks unless stated otherwise.
- ARM: wait for ready = 1, then go to SEARCH in the next cycle. Clear prev_valid and the timeout counter.
- SEARCH: on each tick, store prev = sample_in and set prev_valid. Trigger fires on the tick where prev_valid = 1 and either:
  - rising (trig_slope = 0): prev < trig_level and sample_in >= trig_level;
  - falling (trig_slope = 1): prev > trig_level and sample_in <= trig_level.
- The first tick after entering SEARCH never triggers.
- Auto trigger: the timeout counter increments per tick. If auto_mode = 1 and the counter reaches AUTO_TIMEOUT-1 with no edge, the trigger fires on that tick. With auto_mode = 0 the counter saturates and SEARCH waits indefinitely.
- On trigger: write the trigger sample to data_out[0], set wr_idx = 1, set triggered = 1, go to FILL.
- FILL: on each tick, data_out[wr_idx] <= sample_in and wr_idx++. After writing index DEPTH-1, go to HANDOFF. Exactly DEPTH samples are written, with no wrap-around.
- HANDOFF: read = 1, held (not a pulse) until ready = 0 is sampled. Then read = 0 and go to WAIT_COPY. Ticks are ignored.
- WAIT_COPY: read = 0; wait for ready = 1, then clear triggered and go to ARM. Ticks are ignored.
- data_out holds its values from the end of FILL until the next FILL. The only cells written outside FILL are data_out[0] at the trigger tick and the reset clear.
- Width rules:
  - trigger comparisons are 12-bit unsigned;
  - wr_idx is 9 bits, so 256 is representable and the end test is unambiguous;
  - the timeout counter is clog2(AUTO_TIMEOUT) bits.
- Simultaneous events: an edge and the timeout on the same tick count as a single trigger. sample_valid arriving in the same cycle the FSM enters SEARCH is ignored.
- Reset mid-capture: immediate return to ARM with all outputs at reset values. A partial capture is discarded.
- ready = 0 seen in ARM: stay in ARM (downstream still copying).

Test Plan:
- Rising trigger, decim = 0, level = 2048, ramp 0..4095 step 16 per valid: the trigger fires on the first sample >= 2048. data_out[0] = 2048, data_out[255] = 2048 + 255*16 = 6128 mod-clipped by the source; use ramp step 4 for 3068. read rises one cycle after the last write.
- Falling trigger, level = 1000, descending ramp from 1500 step -2: data_out[0] = 1000, data_out[1] = 998. No trigger on rising segments.
- Auto mode, AUTO_TIMEOUT = 16, constant input 500, level = 2000: the trigger fires on the 16th tick and captures 256 samples of 500. With auto_mode = 0, no read is ever asserted.
- Decim = 3, 1024 valid samples of a counter pattern 0,1,2,...: the captured values step by 4. read stays 1 while ready = 1 and drops the cycle after ready = 0. triggered clears after ready returns to 1.
- Handshake stability: hold ready = 0 for 300 cycles after read and drive new triggering samples. data_out stays unchanged and no new capture starts until ready = 1.
- Async reset asserted mid-FILL (wr_idx = 100): read = 0, triggered = 0, all data_out = 0 with no clock edge needed. After release, the block rearms and completes a normal capture.

Source files
------------

// File: rtl/trigger_capture.sv
// trigger_capture: watches a decimated ADC sample stream for a level crossing of the selected slope,
// or for a timeout in auto mode. It then records DEPTH decimated samples into a parallel array and
// hands them off downstream with a read/ready handshake.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   sample_in    12-bit unsigned ADC sample, qualified by sample_valid
//   sample_valid one-cycle strobe for sample_in
//   trig_level   12-bit unsigned trigger threshold
//   trig_slope   0 = rising-edge trigger, 1 = falling-edge trigger
//   auto_mode    1 = force a trigger after AUTO_TIMEOUT decimated samples
//   decim        keep one of every decim+1 valid samples
//   ready        downstream idle/accepting; low while it copies data_out
//   read         capture complete, held until ready is seen low
//   data_out     captured samples; index 0 is the trigger sample
//   triggered    high from the trigger until the FSM returns to ARM
//   busy         high in every state except ARM
module trigger_capture #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  input  logic [11:0] trig_level,
  input  logic        trig_slope,
  input  logic        auto_mode,
  input  logic [3:0]  decim,
  input  logic        ready,
  output logic        read,
  output logic [11:0] data_out [DEPTH],
  output logic        triggered,
  output logic        busy
);

  localparam int unsigned TW = $clog2(AUTO_TIMEOUT);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [TW-1:0] TMAX     = TW'(AUTO_TIMEOUT - 1);
  localparam logic [8:0]    LAST_IDX = 9'(DEPTH - 1);

  localparam logic [2:0] ST_ARM       = 3'd0;
  localparam logic [2:0] ST_SEARCH    = 3'd1;
  localparam logic [2:0] ST_FILL      = 3'd2;
  localparam logic [2:0] ST_HANDOFF   = 3'd3;
  localparam logic [2:0] ST_WAIT_COPY = 3'd4;

  logic [2:0]    r_state;
  logic [3:0]    r_dcnt;
  logic [11:0]   r_prev;
  logic          r_prev_valid;
  logic [TW-1:0] r_tcnt;
  logic [8:0]    r_wr_idx;
  logic          r_triggered;
  logic [11:0]   r_data [DEPTH];

  logic w_tick;
  logic w_rise;
  logic w_fall;
  logic w_edge;
  logic w_timeout;
  logic w_trig;

  assign w_tick    = sample_valid && (r_dcnt == decim);
  assign w_rise    = (r_prev < trig_level) && (sample_in >= trig_level);
  assign w_fall    = (r_prev > trig_level) && (sample_in <= trig_level);
  assign w_edge    = r_prev_valid && (trig_slope ? w_fall : w_rise);
  // prev_valid guard keeps the first tick after entering SEARCH from ever firing.
  assign w_timeout = auto_mode && r_prev_valid && (r_tcnt == TMAX);
  // Edge and timeout on the same tick collapse into this single trigger.
  assign w_trig    = (r_state == ST_SEARCH) && w_tick && (w_edge || w_timeout);

  // Decimator; cleared in the ARM->SEARCH cycle, which also drops any valid arriving then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dcnt <= '0;
    end else if (r_state == ST_ARM && ready) begin
      r_dcnt <= '0;
    end else if (sample_valid) begin
      r_dcnt <= (r_dcnt == decim) ? 4'd0 : r_dcnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_ARM;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_tcnt       <= '0;
      r_wr_idx     <= '0;
      r_triggered  <= 1'b0;
    end else begin
      case (r_state)
        ST_ARM: begin
          r_prev_valid <= 1'b0;
          r_tcnt       <= '0;
          if (ready) r_state <= ST_SEARCH;
        end
        ST_SEARCH: begin
          if (w_tick) begin
            r_prev       <= sample_in;
            r_prev_valid <= 1'b1;
            if (r_tcnt != TMAX) r_tcnt <= r_tcnt + TW'(1);
            if (w_trig) begin
              r_wr_idx    <= 9'd1;
              r_triggered <= 1'b1;
              r_state     <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (w_tick) begin
            r_wr_idx <= r_wr_idx + 9'd1;
            if (r_wr_idx == LAST_IDX) r_state <= ST_HANDOFF;
          end
        end
        ST_HANDOFF: begin
          if (!ready) r_state <= ST_WAIT_COPY;
        end
        ST_WAIT_COPY: begin
          if (ready) begin
            r_triggered <= 1'b0;
            r_state     <= ST_ARM;
          end
        end
        default: r_state <= ST_ARM;
      endcase
    end
  end

  // Capture array: written only at the trigger tick (cell 0) and during FILL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_data[i] <= '0;
    end else if (w_trig) begin
      r_data[0] <= sample_in;
    end else if (r_state == ST_FILL && w_tick) begin
      r_data[r_wr_idx[IW-1:0]] <= sample_in;
    end
  end

  assign data_out  = r_data;
  assign read      = (r_state == ST_HANDOFF);
  assign busy      = (r_state != ST_ARM);
  assign triggered = r_triggered;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture (DEPTH = 256, AUTO_TIMEOUT = 16).
module tb_trigger_capture;

  logic        clk;
  logic        rst;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic [11:0] trig_level;
  logic        trig_slope;
  logic        auto_mode;
  logic [3:0]  decim;
  logic        ready;
  logic        read;
  logic [11:0] data_out [256];
  logic        triggered;
  logic        busy;

  int vectors;
  int miscompares;

  trigger_capture #(
    .DEPTH       (256),
    .AUTO_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .trig_level  (trig_level),
    .trig_slope  (trig_slope),
    .auto_mode   (auto_mode),
    .decim       (decim),
    .ready       (ready),
    .read        (read),
    .data_out    (data_out),
    .triggered   (triggered),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Present one valid sample, then sit 1 time unit past the edge that consumed it.
  task automatic feed(input logic [11:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Completes a handshake from HANDOFF back into SEARCH.
  task automatic handoff(input string tag);
    idle(2);
    chk({tag, "_read_held"}, 32'(read), 32'd1);
    ready = 1'b0;
    idle(1);
    chk({tag, "_read_drop"}, 32'(read), 32'd0);
    chk({tag, "_trig_in_copy"}, 32'(triggered), 32'd1);
    idle(2);
    ready = 1'b1;
    idle(1);
    chk({tag, "_trig_clear"}, 32'(triggered), 32'd0);
    chk({tag, "_arm_busy"}, 32'(busy), 32'd0);
    idle(1);
    chk({tag, "_search_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    trig_level   = 12'd2048;
    trig_slope   = 1'b0;
    auto_mode    = 1'b0;
    decim        = 4'd0;
    ready        = 1'b1;

    // Reset state
    #3;
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_trig", 32'(triggered), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_d0", 32'(data_out[0]), 32'd0);
    chk("rst_d255", 32'(data_out[255]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    chk("arm_to_search", 32'(busy), 32'd1);

    // Rising trigger, decim 0, level 2048, ramp step 4
    for (int i = 0; i < 512; i++) feed(12'(i * 4));
    chk("rise_no_trig", 32'(triggered), 32'd0);
    feed(12'd2048);
    chk("rise_trig", 32'(triggered), 32'd1);
    for (int i = 1; i < 255; i++) feed(12'(2048 + i * 4));
    chk("rise_read_before_last", 32'(read), 32'd0);
    feed(12'd3068);
    chk("rise_read", 32'(read), 32'd1);
    chk("rise_d0", 32'(data_out[0]), 32'd2048);
    chk("rise_d1", 32'(data_out[1]), 32'd2052);
    chk("rise_d255", 32'(data_out[255]), 32'd3068);

    // Handshake stability: ready low for 300 cycles with triggering samples
    idle(3);
    chk("hold_read_ready1", 32'(read), 32'd1);
    ready = 1'b0;
    idle(1);
    chk("hold_read_drop", 32'(read), 32'd0);
    for (int i = 0; i < 300; i++) feed((i % 2 == 0) ? 12'd0 : 12'd4000);
    chk("hold_d0", 32'(data_out[0]), 32'd2048);
    chk("hold_d255", 32'(data_out[255]), 32'd3068);
    chk("hold_trig", 32'(triggered), 32'd1);
    chk("hold_read", 32'(read), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    ready = 1'b1;
    idle(1);
    chk("hold_release_trig", 32'(triggered), 32'd0);
    chk("hold_release_busy", 32'(busy), 32'd0);
    idle(1);

    // Falling trigger, level 1000
    trig_level = 12'd1000;
    trig_slope = 1'b1;
    feed(12'd900);
    feed(12'd950);
    feed(12'd1050);
    feed(12'd1100);
    feed(12'd1500);
    chk("fall_no_trig_rising", 32'(triggered), 32'd0);
    for (int i = 0; i < 250; i++) feed(12'(1500 - 2 * i));
    chk("fall_no_trig_above", 32'(triggered), 32'd0);
    feed(12'd1000);
    chk("fall_trig", 32'(triggered), 32'd1);
    for (int i = 1; i < 256; i++) feed(12'(1000 - 2 * i));
    chk("fall_read", 32'(read), 32'd1);
    chk("fall_d0", 32'(data_out[0]), 32'd1000);
    chk("fall_d1", 32'(data_out[1]), 32'd998);
    chk("fall_d255", 32'(data_out[255]), 32'd490);
    handoff("fall");

    // Auto trigger on the 16th tick
    trig_level = 12'd2000;
    trig_slope = 1'b0;
    auto_mode  = 1'b1;
    for (int i = 0; i < 15; i++) feed(12'd500);
    chk("auto_no_trig_15", 32'(triggered), 32'd0);
    feed(12'd500);
    chk("auto_trig_16", 32'(triggered), 32'd1);
    for (int i = 1; i < 256; i++) feed(12'd500);
    chk("auto_read", 32'(read), 32'd1);
    chk("auto_d0", 32'(data_out[0]), 32'd500);
    chk("auto_d128", 32'(data_out[128]), 32'd500);
    chk("auto_d255", 32'(data_out[255]), 32'd500);
    handoff("auto");

    // auto_mode off: constant input never triggers
    auto_mode = 1'b0;
    for (int i = 0; i < 40; i++) feed(12'd500);
    chk("noauto_trig", 32'(triggered), 32'd0);
    chk("noauto_read", 32'(read), 32'd0);
    chk("noauto_busy", 32'(busy), 32'd1);

    // Decim 3 on counter pattern: ticks on 3,7,11,...; level 20 fires at 23
    decim      = 4'd3;
    trig_level = 12'd20;
    for (int i = 0; i < 23; i++) feed(12'(i));
    chk("decim_no_trig", 32'(triggered), 32'd0);
    feed(12'd23);
    chk("decim_trig", 32'(triggered), 32'd1);
    for (int i = 24; i < 1044; i++) feed(12'(i));
    chk("decim_read", 32'(read), 32'd1);
    chk("decim_d0", 32'(data_out[0]), 32'd23);
    chk("decim_d1", 32'(data_out[1]), 32'd27);
    chk("decim_d255", 32'(data_out[255]), 32'd1043);
    handoff("decim");
    decim = 4'd0;

    // Async reset mid-FILL at wr_idx 100
    trig_level = 12'd2048;
    for (int i = 0; i < 512; i++) feed(12'(i * 4));
    feed(12'd2048);
    for (int i = 1; i < 100; i++) feed(12'(2048 + i * 4));
    chk("mid_trig", 32'(triggered), 32'd1);
    chk("mid_d99", 32'(data_out[99]), 32'd2444);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_read", 32'(read), 32'd0);
    chk("areset_trig", 32'(triggered), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_d0", 32'(data_out[0]), 32'd0);
    chk("areset_d99", 32'(data_out[99]), 32'd0);
    chk("areset_d255", 32'(data_out[255]), 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    ready = 1'b0;
    idle(3);
    chk("arm_wait_ready", 32'(busy), 32'd0);
    ready = 1'b1;
    idle(2);
    chk("rearm_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 512; i++) feed(12'(i * 4));
    for (int i = 0; i < 256; i++) feed(12'(2048 + i * 4));
    chk("rearm_read", 32'(read), 32'd1);
    chk("rearm_d0", 32'(data_out[0]), 32'd2048);
    chk("rearm_d255", 32'(data_out[255]), 32'd3068);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
